range_addr_streamer: RTL

Command-driven address sequencer that sits directly upstream of the buffer read ports and replaces hand-wired start/end/enable control of an increment-then-stop counter. It accepts inclusive address ranges (start, end) over a valid/ready command port, buffers them, and emits every address in each range in ascending order on a valid/ready stream. It flags the final address of each range and never wraps past the end value, including at the maximum representable address.

---
 rtl/range_addr_streamer_pkg.sv | 9 +
 rtl/sync_cmd_fifo.sv | 39 +++
 rtl/range_addr_streamer.sv | 76 +++++++
 3 files changed

// File: rtl/range_addr_streamer_pkg.sv
// range_addr_streamer_pkg: shared state encoding and parameter defaults for the address streamer.
package range_addr_streamer_pkg;
  localparam int DefBits = 8;
  localparam int DefDepth = 2;
  typedef enum logic [0:0] {
    IDLE,
    STREAM
  } state_e;
endpackage

// File: rtl/sync_cmd_fifo.sv
// sync_cmd_fifo: show-ahead synchronous FIFO with full/empty flags and synchronous active-low reset.
module sync_cmd_fifo #(
  parameter int Width = 16,
  parameter int Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int Aw = Depth > 1 ? $clog2(Depth) : 1;
  localparam int Cw = $clog2(Depth + 1);
  logic [Width-1:0] mem [Depth];
  logic [Aw-1:0] rd_ptr, wr_ptr;
  logic [Cw-1:0] cnt;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign empty = cnt == '0;
  assign full = cnt == Cw'(Depth);
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk_i)
    if (do_push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr == Aw'(Depth - 1) ? '0 : wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr == Aw'(Depth - 1) ? '0 : rd_ptr + 1'b1;
      cnt <= cnt + Cw'(do_push) - Cw'(do_pop);
    end
  end
endmodule

// File: rtl/range_addr_streamer.sv
// range_addr_streamer: buffers inclusive address ranges and streams each address in ascending order.
module range_addr_streamer
  import range_addr_streamer_pkg::*;
#(
  parameter int Bits = DefBits,
  parameter int CmdDepth = DefDepth
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [Bits-1:0] cmd_start_i,
  input  logic [Bits-1:0] cmd_end_i,
  output logic            cmd_err_o,
  output logic            addr_valid_o,
  input  logic            addr_ready_i,
  output logic [Bits-1:0] addr_o,
  output logic            addr_last_o,
  output logic            busy_o
);
  typedef struct packed {
    logic [Bits-1:0] lo;
    logic [Bits-1:0] hi;
  } cmd_t;
  cmd_t head, wcmd;
  state_e state;
  logic [Bits-1:0] cnt, end_q;
  logic full, empty, init_q, err_q, accept, push, pop, fire, at_end;
  // init_q keeps the command port closed until one edge after reset is released
  assign cmd_ready_o = rst_ni & init_q & ~full;
  assign accept = cmd_valid_i & cmd_ready_o;
  assign push = accept & (cmd_start_i <= cmd_end_i);
  assign wcmd = '{lo: cmd_start_i, hi: cmd_end_i};
  assign addr_valid_o = state == STREAM;
  assign at_end = cnt == end_q;
  assign addr_last_o = addr_valid_o & at_end;
  assign fire = addr_valid_o & addr_ready_i;
  assign pop = ~empty & ((state == IDLE) | (fire & at_end));
  assign addr_o = cnt;
  assign cmd_err_o = err_q;
  assign busy_o = addr_valid_o | ~empty;
  sync_cmd_fifo #(
    .Width(2 * Bits),
    .Depth(CmdDepth)
  ) u_fifo (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .push(push),
    .pop(pop),
    .wdata(wcmd),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt <= '0;
      end_q <= '0;
      init_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
      err_q <= accept & (cmd_start_i > cmd_end_i);
      if (pop) begin
        cnt <= head.lo;
        end_q <= head.hi;
        state <= STREAM;
      end else if (fire & at_end) begin
        state <= IDLE;
      end else if (fire) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
